testwave_gen_multi: RTL and testbench
=====================================

# testwave_gen_multi

Parametrised multi-mode test-waveform source for the scope display path. On each sample-enable strobe it advances a waveform of configurable width, period end-point and step, in one of four shapes: ramp up, ramp down, triangle or square. It replaces a fixed 10-bit 0..639 ramp. It feeds synthetic samples to the display/capture logic in place of the microphone stream, so the renderer can be checked against known shapes.

## Interface
Parameters:
- `WIDTH`, 10, sample width in bits.
- `MAX_COUNT`, 639, top sample value. Must be less than 2^WIDTH and at least 1.

Ports:
- `SLOW_CLOCK` in 1. Sole clock; all logic on its rising edge.
- `RESET` in 1. Synchronous, active-high.
- `SAMPLE_EN` in 1. Advance strobe; the waveform moves one step on each edge where it is high.
- `MODE` in 2. Requested shape: 00 ramp up, 01 ramp down, 10 triangle, 11 square.
- `STEP` in WIDTH. Increment per advance, unsigned.
- `wave_sample` out WIDTH. Current sample, registered.
- `wrap` out 1. One-cycle pulse marking the first sample of a new period.
- `active_mode` out 2. Mode currently being generated.

## Operation
Internal state:
- `acc` (WIDTH bits)
- `dir` (1 = up)
- `active_mode`

Start values:
- Ramp up, triangle and square: `acc` = 0.
- Ramp down: `acc` = MAX_COUNT.
- `dir` = up.

Reset behaviour:
- While `RESET` is high, `MODE` is latched into `active_mode` and `acc` is set to that mode's start value.
- `wave_sample` takes the mode's start output: MAX_COUNT for ramp down, else 0.
- `dir` = up, `wrap` = 0.
- Reset overrides `SAMPLE_EN`.

All comparisons and sums use WIDTH+1 bits, so nothing overflows.

On an edge where `SAMPLE_EN` is high, the next `acc` is computed per `active_mode`:
- **Ramp up:** if acc+STEP > MAX_COUNT, wrap; else acc+STEP.
- **Ramp down:** if acc < STEP, wrap; else acc−STEP.
- **Triangle, dir up:** if acc+STEP >= MAX_COUNT, acc = MAX_COUNT and dir = down; else acc+STEP.
- **Triangle, dir down:** if acc <= STEP, wrap; else acc−STEP.
- **Square:** `acc` is a phase counter stepping exactly as in ramp up.

Wrap event:
- `wrap` = 1 for that cycle.
- `MODE` is latched into `active_mode`.
- `acc` is set to the start value of the newly latched mode, with `dir` = up.

Output mapping, updated on the same edge from the next `acc`:
- Square mode: `wave_sample` = MAX_COUNT if acc > MAX_COUNT/2 (integer division), else 0.
- All other modes: `wave_sample` = acc.

Boundary rules:
- `MODE` changes outside a wrap event are ignored until the next wrap. A mode change therefore never truncates a period.
- `SAMPLE_EN` low: all state holds and `wrap` = 0.
- `STEP` = 0: state holds, no wrap. The mode is stuck until reset.
- `STEP` > MAX_COUNT in ramp up: every advance wraps, so the output stays at the start value and `wrap` stays high for each advance.
- Triangle with STEP >= MAX_COUNT: 0 → MAX_COUNT → 0 (wrap), repeating.

## Timing
- The new sample appears on `wave_sample` at the same edge that samples `SAMPLE_EN` high. The output is registered, with no further pipeline delay.
- `wrap` is high in exactly the cycle in which `wave_sample` shows the period's first sample.
- `active_mode` updates on the wrap edge.
- Reset values: `wave_sample` = mode start output, `wrap` = 0, `active_mode` = `MODE` at reset.

## Configuration
`TESTWAVE_SQUARE_EN`:
- **Defined:** mode 11 generates the square wave as specified.
- **Undefined:** the square mapping logic is omitted and mode 11 behaves exactly as ramp up (00), with `active_mode` still reporting 11.

## Test plan
All scenarios use WIDTH=10, MAX_COUNT=639.

- **Ramp up:** reset with MODE=00, STEP=1, SAMPLE_EN=1 → sample 0, then 1..639. The 640th advance gives 0 with `wrap`=1. Repeat for 3 periods.
- **Triangle:** MODE=10, STEP=100 → 0,100,…,600,639,539,439,339,239,139,39, then 0 with `wrap`=1.
- **Ramp down and gated enable:** MODE=01, STEP=200 → 639,439,239,39, then 639 with `wrap`=1. Toggle SAMPLE_EN at 1-in-3 and check the output holds and `wrap` stays low between strobes.
- **Square:** MODE=11, STEP=1 → 320 samples at 0 (phases 0..319), then 320 samples at 639, then 0 with `wrap`=1. Rerun without `TESTWAVE_SQUARE_EN` and check the ramp-up sequence.
- **Deferred mode change:** in ramp up at sample 300, set MODE=10. The ramp continues to 639; then `wrap`=1, sample 0, `active_mode`=10, and the triangle proceeds.
- **Reset mid-period:** assert RESET at triangle sample 539 descending with MODE=01 → next edge sample 639, `wrap`=0, `active_mode`=01. STEP=0 → output frozen indefinitely.

Source files
------------

// File: rtl/testwave_gen_multi.sv
// rtl/testwave_gen_multi.sv - multi-mode test-waveform source for the scope display path
//
// Generates synthetic samples in four shapes: ramp up, ramp down, triangle and
// square. The waveform moves one step on each SAMPLE_EN strobe. The requested
// MODE is only adopted at reset or at a period boundary (wrap), so a period is
// never cut short.
//
// Optional feature macro: TESTWAVE_SQUARE_EN
//   defined   - mode 11 produces a square wave (phase counter compared to half scale)
//   undefined - mode 11 runs exactly as ramp up; active_mode still reports 11
//
// Parameters:
//   WIDTH      sample width in bits
//   MAX_COUNT  top sample value, 1 <= MAX_COUNT < 2**WIDTH
//
// Ports:
//   SLOW_CLOCK   in   sole clock, rising edge
//   RESET        in   synchronous, active-high; latches MODE and loads its start value
//   SAMPLE_EN    in   advance strobe
//   MODE         in   requested shape: 00 ramp up, 01 ramp down, 10 triangle, 11 square
//   STEP         in   unsigned increment per advance
//   wave_sample  out  current sample, registered
//   wrap         out  one-cycle pulse on the first sample of a new period
//   active_mode  out  shape currently being generated

module testwave_gen_multi #(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 639
) (
  input  logic             SLOW_CLOCK,
  input  logic             RESET,
  input  logic             SAMPLE_EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] STEP,
  output logic [WIDTH-1:0] wave_sample,
  output logic             wrap,
  output logic [1:0]       active_mode
);

  typedef enum logic [1:0] {
    MODE_RAMP_UP = 2'b00,
    MODE_RAMP_DN = 2'b01,
    MODE_TRI     = 2'b10,
    MODE_SQUARE  = 2'b11
  } mode_t;

  // One extra bit on the sum so acc+STEP never overflows before comparison.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
`ifdef TESTWAVE_SQUARE_EN
  localparam logic [WIDTH-1:0] HALF_W  = WIDTH'(MAX_COUNT / 2);
`endif

  mode_t            mode_q;
  logic [WIDTH-1:0] acc_q;
  logic             dir_q;      // 1 = counting up (triangle only)

  mode_t            req_mode;
  logic [WIDTH-1:0] start_acc;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_diff;
  logic             adv_wrap;
  logic [WIDTH-1:0] adv_acc;
  logic             adv_dir;
  logic [WIDTH-1:0] adv_sample;

  assign active_mode = mode_q;

  // Start value of the mode that would be latched right now. For every mode
  // the start sample equals the start acc: square starts at phase 0, which
  // maps to the low level.
  always_comb begin
    req_mode  = mode_t'(MODE);
    start_acc = (req_mode == MODE_RAMP_DN) ? MAX_W : '0;
  end

  // Next-state of the waveform for one advance in the currently active mode.
  always_comb begin
    step_sum  = {1'b0, acc_q} + {1'b0, STEP};
    step_diff = acc_q - STEP;  // only used when acc_q >= STEP
    adv_wrap  = 1'b0;
    adv_acc   = acc_q;
    adv_dir   = dir_q;

    case (mode_q)
      MODE_RAMP_UP, MODE_SQUARE: begin
        // Square uses acc as a phase counter that steps like the ramp.
        if (step_sum > MAX_EXT) begin
          adv_wrap = 1'b1;
        end else begin
          adv_acc = step_sum[WIDTH-1:0];
        end
      end

      MODE_RAMP_DN: begin
        if (acc_q < STEP) begin
          adv_wrap = 1'b1;
        end else begin
          adv_acc = step_diff;
        end
      end

      MODE_TRI: begin
        if (dir_q) begin
          // Clamp to the peak so the top value is always shown once.
          if (step_sum >= MAX_EXT) begin
            adv_acc = MAX_W;
            adv_dir = 1'b0;
          end else begin
            adv_acc = step_sum[WIDTH-1:0];
          end
        end else begin
          // Strict '>' keeps the descent from ever emitting 0; the 0 that
          // follows is the first sample of the next period.
          if (acc_q <= STEP) begin
            adv_wrap = 1'b1;
          end else begin
            adv_acc = step_diff;
          end
        end
      end

      default: begin
        adv_wrap = 1'b0;
      end
    endcase
  end

  // Sample mapping for a non-wrapping advance.
  always_comb begin
`ifdef TESTWAVE_SQUARE_EN
    if (mode_q == MODE_SQUARE) begin
      adv_sample = (adv_acc > HALF_W) ? MAX_W : '0;
    end else begin
      adv_sample = adv_acc;
    end
`else
    adv_sample = adv_acc;
`endif
  end

  always_ff @(posedge SLOW_CLOCK) begin
    if (RESET) begin
      mode_q      <= req_mode;
      acc_q       <= start_acc;
      dir_q       <= 1'b1;
      wave_sample <= start_acc;
      wrap        <= 1'b0;
    end else if (SAMPLE_EN) begin
      if (adv_wrap) begin
        // Period boundary: the only place a new MODE is adopted.
        mode_q      <= req_mode;
        acc_q       <= start_acc;
        dir_q       <= 1'b1;
        wave_sample <= start_acc;
        wrap        <= 1'b1;
      end else begin
        acc_q       <= adv_acc;
        dir_q       <= adv_dir;
        wave_sample <= adv_sample;
        wrap        <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_testwave_gen_multi.sv
// tb/tb_testwave_gen_multi.sv - scoreboard bench for testwave_gen_multi
module tb_testwave_gen_multi;

  localparam int W    = 10;
  localparam int MAXC = 639;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic [W-1:0] wave_sample;
  logic         wrap;
  logic [1:0]   active_mode;

  always #5 clk = ~clk;

  testwave_gen_multi #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
    .SLOW_CLOCK  (clk),
    .RESET       (rst),
    .SAMPLE_EN   (en),
    .MODE        (mode),
    .STEP        (step),
    .wave_sample (wave_sample),
    .wrap        (wrap),
    .active_mode (active_mode)
  );

  typedef struct {
    logic [W-1:0] wave;
    logic         wrp;
    logic [1:0]   md;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: a whole period is listed up front as the sequence of
  // samples it must produce; the model just walks the list.
  int per[$];
  int idx;
  int m_active;

  function automatic void build_period(input int md, input int s);
    int v;
    per.delete();
    if (s == 0) begin
      per.push_back(md == 1 ? MAXC : 0);
      return;
    end
    case (md)
      1: begin
        v = MAXC;
        per.push_back(v);
        while (v >= s) begin v -= s; per.push_back(v); end
      end
      2: begin
        v = 0;
        per.push_back(v);
        while (v + s < MAXC) begin v += s; per.push_back(v); end
        v = MAXC;
        per.push_back(v);
        while (v > s) begin v -= s; per.push_back(v); end
      end
      default: begin
        v = 0;
        per.push_back(v);
        while (v + s <= MAXC) begin v += s; per.push_back(v); end
`ifdef TESTWAVE_SQUARE_EN
        if (md == 3) begin
          foreach (per[i]) per[i] = (per[i] > MAXC / 2) ? MAXC : 0;
        end
`endif
      end
    endcase
  endfunction

  task automatic tick(input bit r, input bit e, input int md, input int s);
    exp_t x;
    int   w;
    w    = 0;
    rst  = r;
    en   = e;
    mode = md[1:0];
    step = s[W-1:0];
    if (r) begin
      m_active = md;
      build_period(md, s);
      idx = 0;
    end else if (e && s != 0) begin
      if (idx + 1 < per.size()) begin
        idx++;
      end else begin
        m_active = md;
        build_period(md, s);
        idx = 0;
        w   = 1;
      end
    end
    x.wave = W'(per[idx]);
    x.wrp  = w[0];
    x.md   = m_active[1:0];
    x.cyc  = cyc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (wave_sample !== x.wave) begin
        errors++;
        $display("FAIL wave_sample cyc=%0d got=%0d exp=%0d", x.cyc, wave_sample, x.wave);
      end
      checks++;
      if (wrap !== x.wrp) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%0b exp=%0b", x.cyc, wrap, x.wrp);
      end
      checks++;
      if (active_mode !== x.md) begin
        errors++;
        $display("FAIL active_mode cyc=%0d got=%0d exp=%0d", x.cyc, active_mode, x.md);
      end
    end
  end

  initial begin
    int md;
    int s;
    int r;

    // Ramp up, STEP=1, three full periods.
    tick(1, 0, 0, 1);
    for (int i = 0; i < 3 * 640 + 5; i++) tick(0, 1, 0, 1);

    // Triangle, STEP=100, two periods.
    tick(1, 0, 2, 100);
    for (int i = 0; i < 30; i++) tick(0, 1, 2, 100);

    // Ramp down, STEP=200, continuous then gated 1-in-3.
    tick(1, 0, 1, 200);
    for (int i = 0; i < 12; i++) tick(0, 1, 1, 200);
    for (int i = 0; i < 45; i++) tick(0, (i % 3) == 0, 1, 200);

    // Square, STEP=1, two periods.
    tick(1, 0, 3, 1);
    for (int i = 0; i < 2 * 640 + 3; i++) tick(0, 1, 3, 1);

    // Deferred mode change: request triangle at ramp sample 300.
    tick(1, 0, 0, 1);
    for (int i = 1; i <= 300; i++) tick(0, 1, 0, 1);
    for (int i = 0; i < 340 + 700; i++) tick(0, 1, 2, 1);

    // Reset mid-descent of a triangle, then STEP=0 freezes the output.
    tick(1, 0, 2, 100);
    for (int i = 0; i < 8; i++) tick(0, 1, 2, 100);
    tick(1, 1, 1, 0);
    for (int i = 0; i < 40; i++) tick(0, 1, ((i % 4) == 0) ? 2 : 1, 0);

    // STEP beyond MAX_COUNT in ramp up: every advance wraps.
    tick(1, 0, 0, 700);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 700);

    // Randomised segments with random mode requests and gated enable.
    for (int seg = 0; seg < 12; seg++) begin
      md = int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      s = 0;
      else if (r == 1) s = int'($urandom_range(640, 1023));
      else             s = int'($urandom_range(1, 200));
      tick(1, $urandom_range(0, 1) == 1, md, s);
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) == 0) md = int'($urandom_range(0, 3));
        tick(0, $urandom_range(0, 3) != 0, md, s);
      end
    end

    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
